// File: rtl/jerky_sequence_checker.sv
// Receive-side monitor for the jerky one-hot counter stream: locks onto the
// 4N-3 sample period and flags every sample that departs from it.
module jerky_sequence_checker #(
  parameter int COUNTER_SIZE = 5,
  parameter int ERR_W        = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [COUNTER_SIZE-1:0]         count_in,
  output logic                            locked,
  output logic                            error,
  output logic                            cycle_done,
  output logic                            phase,
  output logic [$clog2(COUNTER_SIZE)-1:0] position,
  output logic [ERR_W-1:0]                err_count
);

  localparam int N     = COUNTER_SIZE;
  localparam int P     = 4 * N - 3;
  localparam int IDX_W = $clog2(P);
  localparam int POS_W = $clog2(N);

  localparam logic [0:0] HUNT   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(P - 1);
  localparam logic [IDX_W-1:0] FALL_FIRST = IDX_W'(2 * N - 2);
  localparam logic [IDX_W-1:0] FALL_LAST  = IDX_W'(4 * N - 5);
  localparam logic [N-1:0]     VEC_R      = N'(1);
  localparam logic [N-1:0]     VEC_2      = N'(2);

  logic [0:0]       state;
  logic [IDX_W-1:0] idx;
  logic [N-1:0]     prev_sample;
  logic             prev_valid;

  logic [IDX_W-1:0] fall_ofs;
  logic             in_fall;
  logic [POS_W-1:0] exp_pos;
  logic [N-1:0]     exp_vec;

  // Expected vector is derived from idx: even slots return to the anchor bit
  // of the current half, odd slots step the excursion bit outward/inward.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    fall_ofs = idx - FALL_FIRST;
    in_fall  = (idx >= FALL_FIRST) && (idx <= FALL_LAST);
    exp_pos  = '0;
    if (idx == LAST_IDX) begin
      exp_pos = '0;
    end else if (!in_fall) begin
      if (idx[0]) exp_pos = POS_W'((idx + 1'b1) >> 1);
    end else if (!fall_ofs[0]) begin
      exp_pos = POS_W'(N - 1);
    end else begin
      exp_pos = POS_W'(IDX_W'(N - 2) - (fall_ofs >> 1));
    end
    exp_vec = VEC_R << exp_pos;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (reset) begin
      state       <= HUNT;
      idx         <= '0;
      prev_sample <= '0;
      prev_valid  <= 1'b0;
      error       <= 1'b0;
      cycle_done  <= 1'b0;
      phase       <= 1'b0;
      position    <= '0;
      err_count   <= '0;
    end else begin
      error      <= 1'b0;
      cycle_done <= 1'b0;
      if (!enable) begin
        // Generator restarts when disabled, so drop alignment without error.
        state      <= HUNT;
        prev_valid <= 1'b0;
      end else if (state == HUNT) begin
        prev_sample <= count_in;
        prev_valid  <= 1'b1;
        if (prev_valid && prev_sample == VEC_R && count_in == VEC_2) begin
          state    <= LOCKED;
          idx      <= IDX_W'(2);
          phase    <= 1'b0;
          position <= POS_W'(1);
        end
      end else if (count_in == exp_vec) begin
        idx        <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        phase      <= in_fall;
        position   <= exp_pos;
        cycle_done <= (idx == LAST_IDX);
      end else begin
        // Keep the bad sample as the HUNT history so re-lock can start at once.
        error       <= 1'b1;
        if (err_count != '1) err_count <= err_count + 1'b1;
        state       <= HUNT;
        prev_sample <= count_in;
        prev_valid  <= 1'b1;
      end
    end
  end

  assign locked = state[0];

endmodule

// File: tb/tb_jerky_sequence_checker.sv
// Bench for jerky_sequence_checker: two instances (wide and 2-bit error
// counter) against a table-driven reference model, directed then random.
module tb_jerky_sequence_checker;

  localparam int N  = 5;
  localparam int P  = 4 * N - 3;
  localparam int PW = $clog2(N);

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [N-1:0]  count_in;

  logic          locked_a, error_a, done_a, phase_a;
  logic [PW-1:0] pos_a;
  logic [7:0]    errc_a;
  logic          locked_b, error_b, done_b, phase_b;
  logic [PW-1:0] pos_b;
  logic [1:0]    errc_b;

  jerky_sequence_checker #(.COUNTER_SIZE(N), .ERR_W(8)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .count_in(count_in),
    .locked(locked_a), .error(error_a), .cycle_done(done_a), .phase(phase_a),
    .position(pos_a), .err_count(errc_a)
  );

  jerky_sequence_checker #(.COUNTER_SIZE(N), .ERR_W(2)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .count_in(count_in),
    .locked(locked_b), .error(error_b), .cycle_done(done_b), .phase(phase_b),
    .position(pos_b), .err_count(errc_b)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int unsigned exp_seq[$];

  // Reference model state
  bit          m_locked, m_error, m_done, m_phase, m_pv;
  int          m_idx, m_pos, m_err;
  int unsigned m_prev;

  int err_pulses  = 0;
  int done_pulses = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int bit_index(input int unsigned v);
    for (int b = 0; b < 32; b++) if (v == (32'd1 << b)) return b;
    return -1;
  endfunction

  task automatic model_step(input bit rst, input bit en, input int unsigned din);
    m_error = 1'b0;
    m_done  = 1'b0;
    if (rst) begin
      m_locked = 0; m_idx = 0; m_pv = 0; m_prev = 0;
      m_phase = 0; m_pos = 0; m_err = 0;
    end else if (!en) begin
      m_locked = 0; m_pv = 0;
    end else if (!m_locked) begin
      if (m_pv && m_prev == 1 && din == 2) begin
        m_locked = 1; m_idx = 2; m_phase = 0; m_pos = 1;
      end
      m_prev = din; m_pv = 1;
    end else if (din == exp_seq[m_idx]) begin
      m_phase = (m_idx >= 2 * (N - 1)) && (m_idx < P - 1);
      m_pos   = bit_index(exp_seq[m_idx]);
      m_done  = (m_idx == P - 1);
      m_idx   = (m_idx + 1) % P;
    end else begin
      m_error = 1; m_err++; m_locked = 0; m_prev = din; m_pv = 1;
    end
  endtask

  task automatic cycle(input bit rst, input bit en, input int unsigned din);
    reset    = rst;
    enable   = en;
    count_in = N'(din);
    @(posedge clk);
    #1;
    model_step(rst, en, din & ((32'd1 << N) - 1));
    if (error_a) err_pulses++;
    if (done_a)  done_pulses++;
    check("locked_a", 32'(locked_a), 32'(m_locked));
    check("error_a",  32'(error_a),  32'(m_error));
    check("done_a",   32'(done_a),   32'(m_done));
    check("phase_a",  32'(phase_a),  32'(m_phase));
    check("pos_a",    32'(pos_a),    32'(m_pos));
    check("errc_a",   32'(errc_a),   32'((m_err > 255) ? 255 : m_err));
    check("locked_b", 32'(locked_b), 32'(m_locked));
    check("error_b",  32'(error_b),  32'(m_error));
    check("errc_b",   32'(errc_b),   32'((m_err > 3) ? 3 : m_err));
  endtask

  task automatic feed(input int start, input int cnt);
    for (int i = 0; i < cnt; i++) cycle(0, 1, exp_seq[(start + i) % P]);
  endtask

  initial begin
    int sp;
    int r;

    for (int j = 1; j <= N - 1; j++) begin
      exp_seq.push_back(1);
      exp_seq.push_back(32'd1 << j);
    end
    for (int m = 0; m <= N - 2; m++) begin
      exp_seq.push_back(32'd1 << (N - 1));
      exp_seq.push_back(32'd1 << (N - 2 - m));
    end
    exp_seq.push_back(1);

    reset = 1'b1; enable = 1'b0; count_in = '0;
    m_locked = 0; m_idx = 0; m_pv = 0; m_prev = 0;
    m_phase = 0; m_pos = 0; m_err = 0; m_error = 0; m_done = 0;

    cycle(1, 1, 0);
    cycle(1, 1, 0);
    check("reset_locked", 32'(locked_a), 0);
    check("reset_errc",   32'(errc_a), 0);

    // Acquire: 01,01,02 then continue
    cycle(0, 1, 1);
    feed(0, 2);
    check("lock_after_02", 32'(locked_a), 1);
    check("lock_position", 32'(pos_a), 1);

    done_pulses = 0;
    feed(2, 15);
    check("done_once_per_period", 32'(done_pulses), 1);
    feed(0, 3);
    check("no_error_after_wrap", 32'(err_pulses), 0);

    // Inject 03 where 04 is expected
    cycle(0, 1, 3);
    check("inj_error_pulse", 32'(error_a), 1);
    check("inj_errc",        32'(errc_a), 1);
    check("inj_unlocked",    32'(locked_a), 0);
    feed(0, 2);
    check("relock_after_err", 32'(locked_a), 1);

    // Enable gap of three cycles, then stream restarts
    feed(2, 4);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0);
    check("gap_unlocked", 32'(locked_a), 0);
    feed(0, 2);
    check("relock_after_gap", 32'(locked_a), 1);
    check("gap_errc_held",    32'(errc_a), 1);

    // Four more mismatches, each followed by re-lock
    for (int k = 0; k < 4; k++) begin
      feed(2, 2);
      cycle(0, 1, 0);
      feed(0, 2);
    end
    check("sat_error_pulses", 32'(err_pulses), 5);
    check("sat_errc_wide",    32'(errc_a), 5);
    check("sat_errc_narrow",  32'(errc_b), 3);

    // Reset mid-period with enable high
    feed(2, 5);
    cycle(1, 1, exp_seq[7]);
    check("midreset_locked", 32'(locked_a), 0);
    check("midreset_errc",   32'(errc_a), 0);
    check("midreset_pos",    32'(pos_a), 0);
    cycle(0, 1, 1);
    feed(0, 2);
    check("relock_after_reset", 32'(locked_a), 1);

    // Randomised stream with corruption, enable drops and resets
    sp = 2;
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 199);
      if (r < 2) begin
        cycle(1, $urandom_range(0, 1), $urandom);
        sp = 0;
      end else if (r < 8) begin
        cycle(0, 0, $urandom);
        sp = 0;
      end else if (r < 16) begin
        cycle(0, 1, $urandom_range(0, (1 << N) - 1));
        sp = (sp + 1) % P;
      end else begin
        cycle(0, 1, exp_seq[sp]);
        sp = (sp + 1) % P;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
